// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - board geometry and scan state encoding shared with the generation engine
package conway_pkg;

    localparam int ADDR_W = 12;
    localparam int ROW_W  = 6;
    localparam int BYTE_W = 8;
    localparam int CELLS  = 1 << ADDR_W;
    localparam int K_W    = 4;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_FETCH,
        SCAN_EMIT,
        SCAN_DONE
    } scan_state_t;

endpackage

// File: rtl/conway_scan_if.sv
// rtl/conway_scan_if.sv - packed-cell byte stream with row/frame markers
interface conway_scan_if;
    import conway_pkg::*;

    logic [BYTE_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              trow;

    modport master (output tdata, output tvalid, output tlast, output trow, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input trow, output tready);

endinterface

// File: rtl/conway_pack8.sv
// rtl/conway_pack8.sv - per-byte fetch counter and LSB-first cell shift register
module conway_pack8
    import conway_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              run,
    input  logic              din,
    output logic [K_W-1:0]    k,
    output logic [BYTE_W-1:0] data,
    output logic              full,
    output logic              shift_en
);

    // k=0 only issues the first address; RAM data trails by one cycle, so
    // samples land on k=1..BYTE_W.
    assign full     = (k == K_W'(BYTE_W));
    assign shift_en = run && (k != '0);

    // fetch sub-counter, parks at BYTE_W until the byte is handed off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (run && !full) begin
            k <= k + K_W'(1);
        end
    end

    // shift in from the top so the first sampled cell ends up in bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {din, data[BYTE_W-1:1]};
        end
    end

endmodule

// File: rtl/conway_scan.sv
// rtl/conway_scan.sv - board RAM readout engine; CONWAY_SCAN_POPCOUNT_EN adds live_count
module conway_scan
    import conway_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_rd,
    output logic              we_rd,
    input  logic              din,
`ifdef CONWAY_SCAN_POPCOUNT_EN
    output logic [ADDR_W:0]   live_count,
`endif
    conway_scan_if.master     strm
);

    scan_state_t       state_q;
    scan_state_t       state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    k_eff;
    logic [BYTE_W-1:0] pack_data;
    logic              full;
    logic              shift_en;
    logic              accept;
    logic              hs;
    logic              last_byte;
    logic              row_end;
    logic              emit;

    assign accept    = (state_q == SCAN_IDLE) && start;
    assign emit      = (state_q == SCAN_EMIT);
    assign hs        = emit && strm.tready;
    assign last_byte = (ptr_q == ADDR_W'(CELLS - BYTE_W));
    assign row_end   = (ptr_q[ROW_W-1:0] == ROW_W'((1 << ROW_W) - BYTE_W));

    // once the last address of the byte is issued it is held through EMIT,
    // so a stalled stream causes no new RAM reads
    assign k_eff   = full ? K_W'(BYTE_W - 1) : k;
    assign addr_rd = ptr_q + {{(ADDR_W-K_W){1'b0}}, k_eff};
    assign we_rd   = 1'b0;

    conway_pack8 u_pack (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept || hs),
        .run      (state_q == SCAN_FETCH),
        .din      (din),
        .k        (k),
        .data     (pack_data),
        .full     (full),
        .shift_en (shift_en)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and status/stream outputs
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        strm.tvalid = 1'b0;
        strm.tlast  = 1'b0;
        strm.trow   = 1'b0;
        strm.tdata  = pack_data;
        case (state_q)
            SCAN_IDLE: begin
                if (start) state_d = SCAN_FETCH;
            end
            SCAN_FETCH: begin
                busy = 1'b1;
                if (full) state_d = SCAN_EMIT;
            end
            SCAN_EMIT: begin
                busy        = 1'b1;
                strm.tvalid = 1'b1;
                strm.tlast  = last_byte;
                strm.trow   = row_end;
                if (strm.tready) state_d = last_byte ? SCAN_DONE : SCAN_FETCH;
            end
            SCAN_DONE: begin
                done    = 1'b1;
                state_d = SCAN_IDLE;
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    // byte base pointer; rewinds to 0 on the final handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= last_byte ? '0 : ptr_q + ADDR_W'(BYTE_W);
        end
    end

`ifdef CONWAY_SCAN_POPCOUNT_EN
    // live-cell tally over the frame, held after done until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_count <= '0;
        end else if (accept) begin
            live_count <= '0;
        end else if (shift_en && din) begin
            live_count <= live_count + (ADDR_W+1)'(1);
        end
    end
`endif

endmodule
